// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op and FSM state encodings for the mult/div engine
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between decode and the mult/div engine
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  import muldiv_unit_pkg::*;

  logic             start;
  op_e              op;
  logic             unsig;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             divzero;

  modport master (
    output start, op, unsig, a, b,
    input  hi, lo, busy, done, divzero
  );

  modport slave (
    input  start, op, unsig, a, b,
    output hi, lo, busy, done, divzero
  );

endinterface

// File: rtl/muldiv_sign.sv
// rtl/muldiv_sign.sv - conditional two's-complement negate
module muldiv_sign #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider with HI/LO
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   ma_q;
  logic [WIDTH-1:0]   mb_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_mult;
  logic               neg_q;
  logic               neg_r;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;
  logic               divzero_q;

  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               accept;

  assign sa = ~bus.unsig & bus.a[WIDTH-1];
  assign sb = ~bus.unsig & bus.b[WIDTH-1];

  // Magnitudes are treated as unsigned, so 0x80000000 stays representable.
  muldiv_sign #(.WIDTH(WIDTH)) u_abs_a (.neg(sa), .din(bus.a), .dout(abs_a));
  muldiv_sign #(.WIDTH(WIDTH)) u_abs_b (.neg(sb), .din(bus.b), .dout(abs_b));

  // FIX accepts a new request so back-to-back ops cost no idle cycle.
  assign accept = bus.start && (state == IDLE || state == FIX);

  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     dsub;
  logic               ge;
  logic [2*WIDTH-1:0] div_next;

  assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? ma_q : {WIDTH{1'b0}})};
  assign mul_next = {msum, acc[WIDTH-1:1]};

  // Remainder in the upper half, dividend shifts out of / quotient shifts into the lower half.
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign dsub     = rem_sh - {1'b0, mb_q};
  assign ge       = ~dsub[WIDTH];
  assign div_next = {(ge ? dsub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  muldiv_sign #(.WIDTH(2*WIDTH)) u_fix_prod (.neg(neg_q), .din(acc), .dout(prod));
  muldiv_sign #(.WIDTH(WIDTH)) u_fix_quo (.neg(neg_q), .din(acc[WIDTH-1:0]), .dout(quo));
  muldiv_sign #(.WIDTH(WIDTH)) u_fix_rem (.neg(neg_r), .din(acc[2*WIDTH-1:WIDTH]), .dout(rem));

  assign res_hi = is_mult ? prod[2*WIDTH-1:WIDTH] : (dz_q ? a_q : rem);
  assign res_lo = is_mult ? prod[WIDTH-1:0] : (dz_q ? {WIDTH{1'b1}} : quo);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_mult   <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        RUN: begin
          acc <= is_mult ? mul_next : div_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi_q      <= res_hi;
          lo_q      <= res_lo;
          done_q    <= 1'b1;
          divzero_q <= dz_q;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
        default: ;
      endcase

      if (accept) begin
        case (bus.op)
          OP_MULT, OP_DIV: begin
            is_mult <= (bus.op == OP_MULT);
            ma_q    <= abs_a;
            mb_q    <= abs_b;
            a_q     <= bus.a;
            neg_q   <= sa ^ sb;
            neg_r   <= sa & (bus.op == OP_DIV);
            dz_q    <= (bus.op == OP_DIV) && (bus.b == '0);
            acc     <= (bus.op == OP_MULT) ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
            cnt     <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
          OP_MTHI: hi_q <= bus.a;
          OP_MTLO: lo_q <= bus.a;
        endcase
      end
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divzero = divzero_q;

endmodule
